// File: rtl/npu8_pkg.sv
// Shared NPU int8 datapath package: requantizer state encodings, default
// widths and int8 range constants.
package npu8_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;
  localparam int LEN_W_DEF  = 16;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic [1:0] {
    Q_ACC_IDLE  = 2'd0,
    Q_ACC_ACCUM = 2'd1,
    Q_ACC_ROUND = 2'd2,
    Q_ACC_SAT   = 2'd3
  } q_acc_state_e;

endpackage

// File: rtl/q_acc_core8_if.sv
// Bus for q_acc_core8: dot-product control, sample stream and result stream.
//
// Handshake semantics: START is a one-cycle request honoured only while BUSY
// is low (no ready, the requester must watch BUSY). INPUT_EN is a valid with
// no back-pressure; samples count only in the ACCUM state and are dropped
// elsewhere. OUTPUT_EN is a one-cycle valid with no ready; Q_OUT and ACC_SAT
// hold their values until the next result. STATE is a debug view of the FSM.
interface q_acc_core8_if #(
  parameter int DATA_W = npu8_pkg::DATA_W_DEF,
  parameter int ACC_W  = npu8_pkg::ACC_W_DEF,
  parameter int LEN_W  = npu8_pkg::LEN_W_DEF
) ();
  import npu8_pkg::*;

  logic                     START;
  logic [LEN_W-1:0]         ACC_LEN;
  logic signed [ACC_W-1:0]  BIAS;
  logic [4:0]               SHIFT;
  logic                     INPUT_EN;
  logic signed [DATA_W-1:0] D_IN;
  logic                     OUTPUT_EN;
  logic signed [DATA_W-1:0] Q_OUT;
  logic                     BUSY;
  logic                     ACC_SAT;
  q_acc_state_e             STATE;

  modport master (
    output START, ACC_LEN, BIAS, SHIFT, INPUT_EN, D_IN,
    input  OUTPUT_EN, Q_OUT, BUSY, ACC_SAT, STATE
  );

  modport slave (
    input  START, ACC_LEN, BIAS, SHIFT, INPUT_EN, D_IN,
    output OUTPUT_EN, Q_OUT, BUSY, ACC_SAT, STATE
  );

endinterface

// File: rtl/q_round_sat8.sv
// Combinational requantizer: rounding arithmetic right shift of a signed
// accumulator, and an int8 clamp of a previously rounded value.
// Build option: Q_ACC_RELU_EN forces negative rounded values to 0 before
// the clamp.
module q_round_sat8
  import npu8_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic [4:0]              shift_i,
  output logic signed [ACC_W:0]   rnd_o,
  input  logic signed [ACC_W:0]   rnd_i,
  output logic signed [7:0]       q_o
);

  localparam int W1 = ACC_W + 1;
  localparam logic signed [W1-1:0] CLIP_HI = W1'(INT8_MAX);
  localparam logic signed [W1-1:0] CLIP_LO = W1'(INT8_MIN);

  logic signed [W1-1:0] wide;
  logic signed [W1-1:0] half;
  logic signed [W1-1:0] sum;
  logic signed [W1-1:0] clip_in;

  // One extra bit of headroom so adding the half-LSB never wraps.
  assign wide  = {acc_i[ACC_W-1], acc_i};
  assign half  = (shift_i == 5'd0) ? '0 : (W1'(1) << (shift_i - 5'd1));
  assign sum   = wide + half;
  assign rnd_o = sum >>> shift_i;

  // Optional ReLU, then clamp to the int8 range.
  always_comb begin
    clip_in = rnd_i;
`ifdef Q_ACC_RELU_EN
    if (rnd_i[W1-1]) clip_in = '0;
`endif
    if (clip_in > CLIP_HI)      q_o = 8'(INT8_MAX);
    else if (clip_in < CLIP_LO) q_o = 8'(INT8_MIN);
    else                        q_o = clip_in[7:0];
  end

endmodule

// File: rtl/q_acc_core8.sv
// q_acc_core8: accumulates ACC_LEN signed int8 products onto a bias with a
// saturating accumulator, then rounds, shifts and clamps the sum to int8.
// Build option: Q_ACC_RELU_EN (handled in q_round_sat8) clamps to 0..127.
module q_acc_core8
  import npu8_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic          CLK,
  input  logic          RESET_X,
  q_acc_core8_if.slave  bus
);

  q_acc_state_e             state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [LEN_W-1:0]         cnt_q;
  logic [LEN_W-1:0]         len_q;
  logic [4:0]               shift_q;
  logic signed [ACC_W:0]    rnd_q;
  logic signed [DATA_W-1:0] q_out_q;
  logic                     out_en_q;
  logic                     acc_sat_q;

  logic [ACC_W:0]           acc_wide;
  logic [ACC_W:0]           din_wide;
  logic [ACC_W:0]           sum_x;
  logic                     acc_ovf;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W:0]    rnd_d;
  logic signed [7:0]        q_d;

  // Saturating accumulate: overflow shows as disagreement of the top two
  // bits of the one-bit-wider sum; clip towards the sign of the true sum.
  assign acc_wide = {acc_q[ACC_W-1], acc_q};
  assign din_wide = {{(ACC_W + 1 - DATA_W){bus.D_IN[DATA_W-1]}}, bus.D_IN};
  assign sum_x    = acc_wide + din_wide;
  assign acc_ovf  = sum_x[ACC_W] ^ sum_x[ACC_W-1];
  assign acc_d    = acc_ovf ? {sum_x[ACC_W], {(ACC_W-1){~sum_x[ACC_W]}}}
                            : sum_x[ACC_W-1:0];

  q_round_sat8 #(
    .ACC_W   (ACC_W)
  ) u_round_sat (
    .acc_i   (acc_q),
    .shift_i (shift_q),
    .rnd_o   (rnd_d),
    .rnd_i   (rnd_q),
    .q_o     (q_d)
  );

  // Controller: IDLE -> ACCUM (or ROUND for zero length) -> ROUND -> SAT.
  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      state_q   <= Q_ACC_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      shift_q   <= '0;
      rnd_q     <= '0;
      q_out_q   <= '0;
      out_en_q  <= 1'b0;
      acc_sat_q <= 1'b0;
    end else begin
      out_en_q <= 1'b0;
      case (state_q)
        Q_ACC_IDLE: begin
          if (bus.START) begin
            len_q     <= bus.ACC_LEN;
            shift_q   <= bus.SHIFT;
            acc_q     <= bus.BIAS;
            cnt_q     <= '0;
            acc_sat_q <= 1'b0;
            state_q   <= (bus.ACC_LEN == '0) ? Q_ACC_ROUND : Q_ACC_ACCUM;
          end
        end
        Q_ACC_ACCUM: begin
          if (bus.INPUT_EN) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + LEN_W'(1);
            if (acc_ovf) acc_sat_q <= 1'b1;
            if (cnt_q == len_q - LEN_W'(1)) state_q <= Q_ACC_ROUND;
          end
        end
        Q_ACC_ROUND: begin
          rnd_q   <= rnd_d;
          state_q <= Q_ACC_SAT;
        end
        Q_ACC_SAT: begin
          q_out_q  <= DATA_W'(q_d);
          out_en_q <= 1'b1;
          state_q  <= Q_ACC_IDLE;
        end
        default: state_q <= Q_ACC_IDLE;
      endcase
    end
  end

  assign bus.OUTPUT_EN = out_en_q;
  assign bus.Q_OUT     = q_out_q;
  assign bus.BUSY      = (state_q != Q_ACC_IDLE);
  assign bus.ACC_SAT   = acc_sat_q;
  assign bus.STATE     = state_q;

endmodule

// File: tb/tb_q_acc_core8.sv
// Testbench for q_acc_core8: directed and randomized dot products checked
// by a queue scoreboard against an arithmetic reference model.
module tb_q_acc_core8;
  import npu8_pkg::*;

  localparam int     DW      = 8;
  localparam longint ACC_MAX = 64'sd8388607;
  localparam longint ACC_MIN = -64'sd8388608;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_x = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  q_acc_core8_if bus ();

  q_acc_core8 dut (
    .CLK     (clk),
    .RESET_X (rst_x),
    .bus     (bus)
  );

  // ---------------- scoreboard state ----------------
  int             chk_cnt  = 0;
  int             pass_cnt = 0;
  logic [DW:0]    exp_q[$];       // {acc_sat, q_out}
  int             exp_cyc_q[$];   // cycle at which OUTPUT_EN must be seen
  longint         drv_samp[$];
  int             drv_stall[$];
  logic [DW:0]    mon_e;
  int             mon_ec;

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: saturating sum, round-half-up shift, optional ReLU, int8 clamp.
  function automatic logic [DW:0] ref_model(input longint bias, input int shift);
    longint acc;
    longint r;
    bit     sat;
    acc = bias;
    sat = 1'b0;
    foreach (drv_samp[i]) begin
      acc = acc + drv_samp[i];
      if (acc > ACC_MAX) begin acc = ACC_MAX; sat = 1'b1; end
      else if (acc < ACC_MIN) begin acc = ACC_MIN; sat = 1'b1; end
    end
    if (shift > 0) acc = acc + (64'sd1 << (shift - 1));
    r = acc >>> shift;
`ifdef Q_ACC_RELU_EN
    if (r < 0) r = 0;
`endif
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return {sat, r[7:0]};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_x && bus.OUTPUT_EN) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output_en", 1, 0);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ec = exp_cyc_q.pop_front();
        check("q_out", longint'(bus.Q_OUT), longint'($signed(mon_e[7:0])));
        check("acc_sat", longint'(bus.ACC_SAT), longint'(mon_e[8]));
        check("output_cycle", cyc, mon_ec);
        check("busy_low_at_output", longint'(bus.BUSY), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One dot product from drv_samp/drv_stall; returns in the OUTPUT_EN cycle
  // so the next call starts back-to-back.
  task automatic run_dot(input int len, input longint bias, input int shift,
                         input bit poke);
    int exp_cyc;
    int stall_sum;
    stall_sum = 0;
    foreach (drv_stall[i]) stall_sum += drv_stall[i];
    exp_cyc = (len == 0) ? cyc + 3 : cyc + 1 + stall_sum + len - 1 + 3;
    exp_q.push_back(ref_model(bias, shift));
    exp_cyc_q.push_back(exp_cyc);
    bus.START   = 1'b1;
    bus.ACC_LEN = 16'(len);
    bus.BIAS    = 24'(bias);
    bus.SHIFT   = 5'(shift);
    step();
    bus.START   = 1'b0;
    bus.ACC_LEN = 16'($urandom);
    bus.BIAS    = 24'($urandom);
    bus.SHIFT   = 5'($urandom);
    check("busy_after_start", longint'(bus.BUSY), 1);
    for (int i = 0; i < len; i++) begin
      for (int j = 0; j < drv_stall[i]; j++) begin
        bus.INPUT_EN = 1'b0;
        bus.D_IN     = 8'($urandom);
        if (poke && j == 0) begin
          bus.START   = 1'b1;
          bus.ACC_LEN = 16'd1;
          bus.BIAS    = 24'($urandom);
        end
        step();
        bus.START = 1'b0;
      end
      bus.INPUT_EN = 1'b1;
      bus.D_IN     = 8'(drv_samp[i]);
      step();
    end
    // Extra samples during ROUND/SAT must be dropped.
    bus.INPUT_EN = poke;
    bus.D_IN     = 8'($urandom);
    while (cyc < exp_cyc) step();
    bus.INPUT_EN = 1'b0;
  endtask

  task automatic set_dot(input longint s0, input longint s1, input longint s2,
                         input int n, input int st);
    drv_samp.delete();
    drv_stall.delete();
    if (n > 0) begin drv_samp.push_back(s0); drv_stall.push_back(st); end
    if (n > 1) begin drv_samp.push_back(s1); drv_stall.push_back(st); end
    if (n > 2) begin drv_samp.push_back(s2); drv_stall.push_back(st); end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_output_en"}, longint'(bus.OUTPUT_EN), 0);
    check({tag, "_q_out"}, longint'(bus.Q_OUT), 0);
    check({tag, "_busy"}, longint'(bus.BUSY), 0);
    check({tag, "_acc_sat"}, longint'(bus.ACC_SAT), 0);
    check({tag, "_state"}, longint'(bus.STATE), longint'(Q_ACC_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int     len;
    int     shift;
    longint bias;
    logic [23:0] b24;
    bus.START = 1'b0; bus.ACC_LEN = '0; bus.BIAS = '0; bus.SHIFT = '0;
    bus.INPUT_EN = 1'b0; bus.D_IN = '0;
    rst_x = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_x = 1'b1;
    step();

    // Basic dot product: 1+2+3+4.
    drv_samp  = '{1, 2, 3, 4};
    drv_stall = '{0, 0, 0, 0};
    run_dot(4, 0, 0, 0);
    // Rounding with stalls: (5-1+2+2)>>2 = 2.
    drv_samp  = '{-1, 2};
    drv_stall = '{0, 3};
    run_dot(2, 5, 2, 0);
    // Output clamp high and low.
    set_dot(127, 127, 127, 3, 0);
    run_dot(3, 0, 0, 0);
    set_dot(-128, -128, -128, 3, 0);
    run_dot(3, 0, 0, 0);
    // Accumulator saturation: clips at 2^23-1 before adding -128.
    set_dot(127, -128, 0, 2, 0);
    run_dot(2, ACC_MAX - 99, 0, 0);
    // Zero length, then back-to-back with a START poked mid-ACCUM.
    set_dot(0, 0, 0, 0, 0);
    run_dot(0, -3, 0, 0);
    drv_samp  = '{10, -20, 30};
    drv_stall = '{2, 1, 0};
    run_dot(3, 100, 1, 1);

    // Randomized dot products.
    for (int n = 0; n < 40; n++) begin
      len   = $urandom_range(0, 6);
      shift = $urandom_range(0, 23);
      case ($urandom_range(0, 3))
        0: bias = longint'($urandom_range(0, 400)) - 200;
        1: begin b24 = 24'($urandom); bias = longint'($signed(b24)); end
        2: bias = ACC_MAX - longint'($urandom_range(0, 300));
        default: bias = ACC_MIN + longint'($urandom_range(0, 300));
      endcase
      drv_samp.delete();
      drv_stall.delete();
      for (int i = 0; i < len; i++) begin
        drv_samp.push_back(longint'($urandom_range(0, 255)) - 128);
        drv_stall.push_back($urandom_range(0, 2));
      end
      run_dot(len, bias, shift, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) begin
        // Idle gap with stray samples that IDLE must ignore.
        bus.INPUT_EN = 1'b1;
        bus.D_IN     = 8'($urandom);
        step();
        step();
        bus.INPUT_EN = 1'b0;
      end
    end

    // Reset mid-ACCUM after 2 of 4 samples, with a nonzero Q_OUT held.
    drv_samp  = '{1, 2, 3, 4};
    drv_stall = '{0, 0, 0, 0};
    run_dot(4, 0, 0, 0);
    drain();
    bus.START = 1'b1; bus.ACC_LEN = 16'd4; bus.BIAS = 24'd50; bus.SHIFT = 5'd0;
    step();
    bus.START = 1'b0;
    bus.INPUT_EN = 1'b1; bus.D_IN = 8'd7;
    step();
    step();
    bus.INPUT_EN = 1'b0;
    rst_x = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    step();
    step();
    rst_x = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.INPUT_EN = i[0];
      bus.D_IN     = 8'($urandom);
      step();
    end
    bus.INPUT_EN = 1'b0;
    check("post_reset_busy", longint'(bus.BUSY), 0);
    drv_samp  = '{1, 2, 3, 4};
    drv_stall = '{0, 1, 0, 0};
    run_dot(4, 0, 0, 0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/q_acc_core8.md
# q_acc_core8

Downstream accumulate-and-requantize stage for the int8 multiplier lane. It consumes the lane's per-cycle signed 8-bit products (C_OUT/OUTPUT_EN) and accumulates ACC_LEN of them onto a bias. It then applies a rounding arithmetic right shift and saturates the result back to int8. One int8 dot-product result is emitted per START, which makes the block the tail of a vector-dot-product lane in the NPU datapath.

## Interface
- DATA_W, 8, input/output sample width (signed)
- ACC_W, 24, accumulator width (signed)
- LEN_W, 16, width of ACC_LEN
- CLK  in  1  clock, all state updates on rising edge
- RESET_X  in  1  reset, asynchronous, active-low
- START  in  1  one-cycle pulse; latches ACC_LEN/BIAS/SHIFT and begins a dot product
- ACC_LEN  in  LEN_W  number of samples to accumulate
- BIAS  in  ACC_W  signed initial accumulator value
- SHIFT  in  5  requantization right shift, 0..ACC_W-1
- INPUT_EN  in  1  D_IN valid this cycle, driven by the multiplier lane's OUTPUT_EN
- D_IN  in  DATA_W  signed product sample, driven by the multiplier lane's C_OUT
- OUTPUT_EN  out  1  one-cycle pulse: Q_OUT holds a new result
- Q_OUT  out  DATA_W  signed requantized result, held until the next result
- BUSY  out  1  high in every state except IDLE
- ACC_SAT  out  1  sticky per dot product; high if the accumulator clipped during it

## Operation
- States: IDLE, ACCUM, ROUND, SAT. Encoding: IDLE=0, ACCUM=1, ROUND=2, SAT=3.
- IDLE:
  - On START: latch len_r/shift_r, set acc <= BIAS, cnt <= 0, clear ACC_SAT.
  - Next state is ACCUM, or ROUND if ACC_LEN==0. With ACC_LEN==0 the result is the requantized bias.
  - INPUT_EN in IDLE is ignored.
- ACCUM:
  - Each cycle with INPUT_EN=1: acc <= sat_ACC_W(acc + sext(D_IN)), cnt <= cnt+1.
  - When INPUT_EN=1 and cnt==len_r-1, go to ROUND.
  - Cycles with INPUT_EN=0 are stalls: no change.
- Accumulator saturation:
  - Clips to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clip sets ACC_SAT.
  - A clipped acc is not rewound if later samples would bring it back in range.
- ROUND:
  - rnd <= (acc + (SHIFT>0 ? 2^(shift_r-1) : 0)) >>> shift_r.
  - The add uses an ACC_W+1-bit intermediate, so there is no wrap.
- SAT: Q_OUT <= clamp(rnd, -128, 127), OUTPUT_EN <= 1, then return to IDLE.
- START while BUSY is ignored; a dot product in flight is never restarted.
- INPUT_EN in ROUND or SAT is dropped. The controller must not send extra samples.
- Reset mid-operation: state returns to IDLE and all partial accumulation is discarded.

## Timing
- Reset values: OUTPUT_EN=0, Q_OUT=0, BUSY=0, ACC_SAT=0, state IDLE, acc=0, cnt=0.
- START sampled at edge s: BUSY=1 from s. The first sample is accepted at edge s+1 or later.
- Last sample accepted at edge k: ROUND at k+1, SAT at k+2, OUTPUT_EN=1 and Q_OUT valid after k+3 for exactly one cycle.
- Latency: 3 cycles from last INPUT_EN to OUTPUT_EN.
- ACC_LEN==0: OUTPUT_EN is high 3 cycles after START.
- BUSY falls in the same cycle OUTPUT_EN rises.
- A START in the OUTPUT_EN cycle is accepted, so back-to-back dot products lose no cycle.
- Minimum period per dot product: ACC_LEN+3 cycles.

## Configuration
- Q_ACC_RELU_EN:
  - Defined: in SAT, negative rnd is forced to 0 before the int8 clamp, so Q_OUT is in 0..127.
  - Undefined: full signed clamp to -128..127.
  - ACC_SAT behaviour is identical in both builds.

## Structure
- Shared package npu8_pkg holds:
  - state encodings Q_ACC_IDLE/ACCUM/ROUND/SAT
  - default DATA_W/ACC_W/LEN_W constants
  - INT8_MAX/INT8_MIN constants
- One sub-module, q_round_sat8: combinational round-shift plus int8 clamp, including the RELU option. It is instantiated between the ROUND and SAT registers and is reusable by other requantizing stages.

## Test plan
- Basic dot product:
  - Stimulus: BIAS=0, SHIFT=0, ACC_LEN=4, D_IN=1,2,3,4 on consecutive cycles.
  - Required: Q_OUT=10, OUTPUT_EN pulses 3 cycles after the 4th sample, ACC_SAT=0.
- Rounding and stalls:
  - Stimulus: BIAS=5, SHIFT=2, ACC_LEN=2, D_IN=-1,+2 with 3 stall cycles between them.
  - Required: Q_OUT=2 ((6+2)>>2), and stalls do not change the count.
- Output clamp:
  - Stimulus: ACC_LEN=3, D_IN=127,127,127, SHIFT=0.
  - Required: Q_OUT=127.
  - Same test with D_IN=-128 x3: Q_OUT=-128; with Q_ACC_RELU_EN defined, Q_OUT=0.
- Accumulator saturation:
  - Stimulus: BIAS=2^23-100, ACC_LEN=2, D_IN=127,-128.
  - Required: ACC_SAT=1; Q_OUT=127 with SHIFT=0; acc was clipped at 2^23-1 before adding -128.
- Zero length and back-to-back:
  - Stimulus: ACC_LEN=0, BIAS=-3, SHIFT=0.
  - Required: Q_OUT=-3 three cycles after START.
  - A second START in the OUTPUT_EN cycle is accepted; a START issued mid-ACCUM is ignored.
- Reset mid-ACCUM:
  - Stimulus: deassert RESET_X after 2 of 4 samples.
  - Required: all outputs return to their reset values, and no OUTPUT_EN appears until a new START completes.
